// File: rtl/i2c_read_arbiter.sv
// i2c_read_arbiter: round-robin arbiter sharing one single-byte I2C read master among NUM_REQ requesters,
// with a watchdog that aborts a transaction the master keeps retrying.
module i2c_read_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [7*NUM_REQ-1:0] i_dev_addr_bus,
    input  logic [8*NUM_REQ-1:0] i_data_addr_bus,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [7:0]           o_rdata,
    output logic                 o_err,
    output logic                 o_busy,
    output logic [2:0]           o_grant_id,
    output logic                 o_i2c_recv_en,
    output logic [6:0]           o_device_addr,
    output logic [7:0]           o_data_addr,
    input  logic [7:0]           i_read_data,
    input  logic                 i_done_flag
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t             r_state, w_state_nxt;
    logic [TW-1:0]      r_timer, w_timer_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt, r_grant_id, w_grant_id_nxt, w_win;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [7:0]         r_rdata, w_rdata_nxt, r_data_addr, w_data_addr_nxt, w_data_sel;
    logic [6:0]         r_device_addr, w_device_addr_nxt, w_dev_sel;
    logic               r_err, w_err_nxt, r_busy, w_busy_nxt, r_en, w_en_nxt;
    logic [3:0]         w_idx;
    logic [7:0]         w_req8;

    assign w_req8 = 8'(i_req);

    // Search from the highest offset down so the nearest requester after ptr is the last (winning) assignment.
    always_comb begin
        w_win      = '0;
        w_idx      = '0;
        w_dev_sel  = '0;
        w_data_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = 4'(r_ptr) + 4'(i) + 4'd1;
            if (w_idx >= 4'(NUM_REQ))
                w_idx = w_idx - 4'(NUM_REQ);
            if (w_req8[w_idx[2:0]])
                w_win = w_idx[2:0];
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (w_win == 3'(k)) begin
                w_dev_sel  = i_dev_addr_bus[7*k +: 7];
                w_data_sel = i_data_addr_bus[8*k +: 8];
            end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_ptr_nxt         = r_ptr;
        w_grant_id_nxt    = r_grant_id;
        w_ack_nxt         = '0;
        w_rdata_nxt       = r_rdata;
        w_err_nxt         = r_err;
        w_busy_nxt        = r_busy;
        w_en_nxt          = r_en;
        w_device_addr_nxt = r_device_addr;
        w_data_addr_nxt   = r_data_addr;
        if (r_state == IDLE) begin
            if (|i_req) begin
                w_ptr_nxt         = w_win;
                w_grant_id_nxt    = w_win;
                w_device_addr_nxt = w_dev_sel;
                w_data_addr_nxt   = w_data_sel;
                w_busy_nxt        = 1'b1;
                w_en_nxt          = 1'b1;
                w_timer_nxt       = '0;
                w_state_nxt       = RUN;
            end
        end else if (r_state == RUN) begin
            w_timer_nxt = (&r_timer) ? r_timer : r_timer + TW'(1);
            // Done is checked first so a done arriving on the timeout edge still returns good data.
            if (i_done_flag || r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                w_rdata_nxt = i_done_flag ? i_read_data : 8'h00;
                w_err_nxt   = !i_done_flag;
                w_ack_nxt   = NUM_REQ'(1) << r_grant_id;
                w_en_nxt    = 1'b0;
                w_timer_nxt = '0;
                w_state_nxt = RELEASE;
            end
        end else if (r_state == RELEASE) begin
            if (r_timer >= TW'(GAP_CYCLES - 1)) begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end else begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end else begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_ptr         <= 3'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_ack         <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_en          <= 1'b0;
            r_device_addr <= '0;
            r_data_addr   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_ack         <= w_ack_nxt;
            r_rdata       <= w_rdata_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= w_busy_nxt;
            r_en          <= w_en_nxt;
            r_device_addr <= w_device_addr_nxt;
            r_data_addr   <= w_data_addr_nxt;
        end
    end

    assign o_ack         = r_ack;
    assign o_rdata       = r_rdata;
    assign o_err         = r_err;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant_id;
    assign o_i2c_recv_en = r_en;
    assign o_device_addr = r_device_addr;
    assign o_data_addr   = r_data_addr;
endmodule
